// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with single-cycle hit latency.
// Misses fetch a whole line through an ascending-order burst read port.
module inst_cache #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INST_W     = 32,
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  input  logic              stall,
  output logic              inst_enable,
  output logic [INST_W-1:0] inst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata
);

  localparam int unsigned WordB  = $clog2(LINE_WORDS);
  localparam int unsigned IndexB = $clog2(LINES);
  localparam int unsigned IdxLsb = 2 + WordB;
  localparam int unsigned TagLsb = IdxLsb + IndexB;
  localparam int unsigned TagB   = ADDR_W - TagLsb;

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e            state_q;
  logic [LINES-1:0]  valid_q;
  logic [WordB-1:0]  beat_q;

  logic [INST_W-1:0] data_mem [LINES*LINE_WORDS];
  logic [TagB-1:0]   tag_mem  [LINES];

  logic [WordB-1:0]  req_word;
  logic [IndexB-1:0] req_index;
  logic [TagB-1:0]   req_tag;
  logic [IndexB-1:0] fill_index;
  logic [TagB-1:0]   fill_tag;
  logic              accept;
  logic              hit;
  logic              beat_write;
  logic              last_beat;
  logic              unused_addr_bits;

  assign req_word   = addr[2 +: WordB];
  assign req_index  = addr[IdxLsb +: IndexB];
  assign req_tag    = addr[TagLsb +: TagB];
  // The latched fill address doubles as the fill line pointer.
  assign fill_index = mem_addr[IdxLsb +: IndexB];
  assign fill_tag   = mem_addr[TagLsb +: TagB];

  assign unused_addr_bits = ^addr[1:0];

  assign accept     = (state_q == StIdle) && ce && !stall;
  assign hit        = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign beat_write = (state_q == StFill) && mem_rvalid;
  assign last_beat  = beat_write && (beat_q == WordB'(LINE_WORDS - 1));

  // Storage arrays carry no reset; validity is tracked by valid_q alone.
  always_ff @(posedge clk) begin
    if (beat_write) begin
      data_mem[{fill_index, beat_q}] <= mem_rdata;
    end
    if (last_beat) begin
      tag_mem[fill_index] <= fill_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      beat_q      <= '0;
      inst_enable <= 1'b0;
      inst        <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else begin
      inst_enable <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (hit) begin
              inst_enable <= 1'b1;
              inst        <= data_mem[{req_index, req_word}];
            end else begin
              state_q            <= StFill;
              mem_req            <= 1'b1;
              mem_addr           <= {req_tag, req_index, {(WordB + 2){1'b0}}};
              valid_q[req_index] <= 1'b0;
              beat_q             <= '0;
            end
          end
        end
        StFill: begin
          if (beat_write) begin
            if (last_beat) begin
              valid_q[fill_index] <= 1'b1;
              mem_req             <= 1'b0;
              beat_q              <= '0;
              state_q             <= StDone;
            end else begin
              beat_q <= beat_q + WordB'(1);
            end
          end
        end
        // Bubble cycle: the PC may have moved, so the next lookup starts fresh.
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  mem_addr_stable_a : assert property (@(posedge clk) disable iff (rst)
    (mem_req && $past(mem_req)) |-> (mem_addr == $past(mem_addr)));

  fill_line_invalid_a : assert property (@(posedge clk) disable iff (rst)
    (state_q == StFill) |-> !valid_q[fill_index]);

  mem_req_in_fill_a : assert property (@(posedge clk) disable iff (rst)
    mem_req == (state_q == StFill));

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, hit stream, stall, conflict eviction,
// PC redirect during a fill and reset in the middle of a fill.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        stall;
  logic        inst_enable;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .addr       (addr),
    .stall      (stall),
    .inst_enable(inst_enable),
    .inst       (inst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Four back-to-back beats d0..d0+3; FSM sits in DONE on return.
  task automatic fill(input logic [31:0] d0);
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = d0 + 32'(i);
      tick();
      check("fill_no_pulse", 32'(inst_enable), 32'd0);
    end
    mem_rvalid = 1'b0;
  endtask

  // From DONE: one bubble, then the re-presented request hits.
  task automatic serve(input logic [31:0] exp);
    check("done_req_low", 32'(mem_req), 32'd0);
    tick();
    check("bubble_no_pulse", 32'(inst_enable), 32'd0);
    tick();
    check("serve_en", 32'(inst_enable), 32'd1);
    check("serve_inst", inst, exp);
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    tick();
    check("hit_en", 32'(inst_enable), 32'd1);
    check("hit_inst", inst, exp);
    check("hit_no_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    ce         = 1'b0;
    addr       = '0;
    stall      = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    check("rst_en", 32'(inst_enable), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    rst = 1'b0;

    // Cold miss
    ce   = 1'b1;
    addr = 32'h10;
    tick();
    check("t1_req", 32'(mem_req), 32'd1);
    check("t1_maddr", mem_addr, 32'h10);
    check("t1_en", 32'(inst_enable), 32'd0);
    fill(32'hA0);
    serve(32'hA0);

    // Hit stream
    hit(32'h10, 32'hA0);
    hit(32'h14, 32'hA1);
    hit(32'h18, 32'hA2);
    hit(32'h1C, 32'hA3);

    // Stall
    addr  = 32'h14;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_stall_en", 32'(inst_enable), 32'd0);
      check("t3_stall_inst", inst, 32'hA3);
    end
    stall = 1'b0;
    tick();
    check("t3_en", 32'(inst_enable), 32'd1);
    check("t3_inst", inst, 32'hA1);

    // Conflict on index 1
    addr = 32'h410;
    tick();
    check("t4_req", 32'(mem_req), 32'd1);
    check("t4_maddr", mem_addr, 32'h410);
    fill(32'hB0);
    serve(32'hB0);
    addr = 32'h10;
    tick();
    check("t4_remiss_en", 32'(inst_enable), 32'd0);
    check("t4_remiss_req", 32'(mem_req), 32'd1);
    check("t4_remiss_maddr", mem_addr, 32'h10);
    fill(32'hA0);
    serve(32'hA0);

    // Redirect during fill
    addr = 32'h100;
    tick();
    check("t5_maddr", mem_addr, 32'h100);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hC0;
    tick();
    mem_rdata  = 32'hC1;
    tick();
    addr       = 32'h14;
    mem_rdata  = 32'hC2;
    tick();
    check("t5_mid_req", 32'(mem_req), 32'd1);
    check("t5_mid_maddr", mem_addr, 32'h100);
    mem_rdata  = 32'hC3;
    tick();
    mem_rvalid = 1'b0;
    check("t5_last_en", 32'(inst_enable), 32'd0);
    serve(32'hA1);

    // Reset mid-fill
    addr = 32'h500;
    tick();
    check("t6_maddr", mem_addr, 32'h500);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hD0;
    tick();
    mem_rdata  = 32'hD1;
    tick();
    rst       = 1'b1;
    ce        = 1'b0;
    mem_rdata = 32'hD2;
    #1;
    check("t6_rst_req", 32'(mem_req), 32'd0);
    check("t6_rst_maddr", mem_addr, 32'd0);
    tick();
    rst       = 1'b0;
    mem_rdata = 32'hD3;
    tick();
    check("t6_late_req", 32'(mem_req), 32'd0);
    check("t6_late_en", 32'(inst_enable), 32'd0);
    mem_rvalid = 1'b0;
    ce         = 1'b1;
    addr       = 32'h100;
    tick();
    check("t6_remiss_req", 32'(mem_req), 32'd1);
    check("t6_remiss_maddr", mem_addr, 32'h100);
    fill(32'hE0);
    serve(32'hE0);
    hit(32'h10C, 32'hE3);
    addr = 32'h10;
    tick();
    check("t6_cleared_req", 32'(mem_req), 32'd1);
    check("t6_cleared_en", 32'(inst_enable), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
